// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: control bundle plus NDATA words behind a valid/ready handshake,
// with flush, optional 2-entry skid buffer, occupancy and saturating stall counter.
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NDATA  = 4,
   parameter int unsigned CTRL_W = 5,
   parameter int unsigned SKID   = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CTRL_W-1:0]       in_ctrl,
   input  logic [NDATA*DATA_W-1:0] in_data,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CTRL_W-1:0]       out_ctrl,
   output logic [NDATA*DATA_W-1:0] out_data,
   output logic [1:0]              occupancy,
   output logic [15:0]             stall_cnt
);

   localparam int unsigned DW = NDATA * DATA_W;

   logic              main_valid_q, main_valid_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DW-1:0]     main_data_q, main_data_d;
   logic              skid_valid_q, skid_valid_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DW-1:0]     skid_data_q, skid_data_d;
   logic              in_ready_q, in_ready_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;
   logic              accept;

   assign in_ready = (SKID != 0) ? in_ready_q : (!main_valid_q | out_ready);
   assign accept   = in_valid & in_ready;

   // Held ctrl/data are zeroed whenever an entry is vacated, so empty stages emit bubbles.
   always_comb begin
      main_valid_d = main_valid_q;
      main_ctrl_d  = main_ctrl_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         main_valid_d = 1'b0;
         main_ctrl_d  = '0;
         main_data_d  = '0;
         skid_valid_d = 1'b0;
         skid_ctrl_d  = '0;
         skid_data_d  = '0;
      end else if (skid_valid_q) begin
         if (out_ready) begin
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
            skid_data_d  = '0;
         end
      end else if (main_valid_q) begin
         if (accept) begin
            if (out_ready) begin
               main_ctrl_d = in_ctrl;
               main_data_d = in_data;
            end else if (SKID != 0) begin
               skid_valid_d = 1'b1;
               skid_ctrl_d  = in_ctrl;
               skid_data_d  = in_data;
            end
         end else if (out_ready) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            main_data_d  = '0;
         end
      end else if (accept) begin
         main_valid_d = 1'b1;
         main_ctrl_d  = in_ctrl;
         main_data_d  = in_data;
      end
      in_ready_d = !skid_valid_d;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (main_valid_q && !out_ready && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_valid_q <= 1'b0;
         main_ctrl_q  <= '0;
         main_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_ctrl_q  <= '0;
         skid_data_q  <= '0;
         in_ready_q   <= 1'b1;
         stall_cnt_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_ctrl_q  <= main_ctrl_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= in_ready_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign out_valid = main_valid_q;
   assign out_ctrl  = main_ctrl_q;
   assign out_data  = main_data_q;
   assign occupancy = skid_valid_q ? 2'd2 : {1'b0, main_valid_q};
   assign stall_cnt = stall_cnt_q;

endmodule
